// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit:
// FSM states, ALU/cond-code localparams, mux encodings and the data-processing decode helper.
package cu_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, LINK
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  typedef struct packed {
    logic [3:0] ctrl;     // ALU operation
    logic       writes;   // result goes to Rd
    logic       sets_cv;  // arithmetic op: C and V are meaningful
  } alu_dec_t;

  // Unknown commands fall back to ADD with no register write.
  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    d.ctrl    = ALU_ADD;
    d.writes  = 1'b1;
    d.sets_cv = 1'b0;
    case (cmd)
      CMD_ADD: d.sets_cv = 1'b1;
      CMD_SUB: begin d.ctrl = ALU_SUB; d.sets_cv = 1'b1; end
      CMD_CMP: begin d.ctrl = ALU_SUB; d.sets_cv = 1'b1; d.writes = 1'b0; end
      CMD_AND: d.ctrl = ALU_AND;
      CMD_ORR: d.ctrl = ALU_ORR;
      CMD_MOV: d.ctrl = ALU_PASSB;
      default: d.writes = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_logic.sv
// Architectural NZCV flag register with split N/Z and C/V update enables,
// plus the combinational ARM condition-code check against the registered flags.
module cond_logic
  import cu_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              flag_write_nz,
  input  logic              flag_write_cv,
  output logic              cond_ok,
  output logic [FLAG_W-1:0] flags
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else begin
      if (flag_write_nz) flags[3:2] <= alu_flags[3:2];
      if (flag_write_cv) flags[1:0] <= alu_flags[1:0];
    end
  end

  // cond=1111 (NV) never executes.
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = ~z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = ~c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = ~n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = ~v;
      COND_HI: cond_ok = c & ~z;
      COND_LS: cond_ok = ~c | z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = ~z & (n == v);
      COND_LE: cond_ok = z | (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the shared-memory ARM-subset datapath (FETCH..WRITEBACK).
// Optional macro CU_BRANCH_LINK_EN adds a LINK cycle that writes PC-4 to R14 for BL.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ALU_CTRL_W  = 4,
  parameter int FLAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [19:0]           instruction,
  input  logic [FLAG_W-1:0]     alu_flags,
  input  logic                  sh_imm,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic                  sh_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_instr
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  assign cond  = instruction[19:16];
  assign op    = instruction[15:14];
  assign funct = instruction[13:8];
  assign rd    = instruction[3:0];

  logic unused_rn;
  assign unused_rn = ^instruction[7:4];

  state_t          state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  alu_dec_t        dp;
  logic            cond_ok;
  logic            flag_write_nz, flag_write_cv;
  logic [FLAG_W-1:0] flags;

  assign dp = alu_decode(funct[4:1]);

  cond_logic #(.FLAG_W(FLAG_W)) u_cond (
    .clk           (clk),
    .reset         (reset),
    .cond          (cond),
    .alu_flags     (alu_flags),
    .flag_write_nz (flag_write_nz),
    .flag_write_cv (flag_write_cv),
    .cond_ok       (cond_ok),
    .flags         (flags)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   wait_cnt <= '0;
    else if (state == MEMRD && wait_cnt != CNT_LAST) wait_cnt <= wait_cnt + CNT_W'(1);
    else                                         wait_cnt <= '0;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (op)
          2'b00: next_state = funct[5] ? EXECI : EXECR;
          2'b01: next_state = MEMADR;
`ifdef CU_BRANCH_LINK_EN
          2'b10: next_state = funct[4] ? LINK : BRANCH;
`else
          2'b10: next_state = BRANCH;
`endif
          default: next_state = FETCH;
        endcase
      end
      EXECR, EXECI: next_state = ALUWB;
      MEMADR:  next_state = funct[0] ? MEMRD : MEMWR;
      MEMRD:   next_state = (wait_cnt == CNT_LAST) ? MEMWB : MEMRD;
      LINK:    next_state = BRANCH;
      default: next_state = FETCH;
    endcase
  end

  // Flags commit on the last EXEC cycle; C/V only from arithmetic commands.
  always_comb begin
    flag_write_nz = 1'b0;
    flag_write_cv = 1'b0;
    if ((state == EXECR || state == EXECI) && funct[0] && cond_ok) begin
      flag_write_nz = 1'b1;
      flag_write_cv = dp.sets_cv;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    imm_src       = IMM_8;
    reg_src       = 2'b00;
    sh_src        = 1'b0;
    alu_control   = ALU_CTRL_W'(ALU_ADD);
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
      end
      DECODE: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_FOUR;
        illegal_instr = (op == 2'b11);
      end
      EXECR: begin
        alu_control = ALU_CTRL_W'(dp.ctrl);
        sh_src      = sh_imm;
      end
      EXECI: begin
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_CTRL_W'(dp.ctrl);
      end
      ALUWB: begin
        alu_control = ALU_CTRL_W'(dp.ctrl);
        reg_write   = cond_ok & dp.writes;
        pc_write    = cond_ok & dp.writes & (rd == 4'd15);
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_12;
      end
      MEMRD: adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = cond_ok;
        pc_write   = cond_ok & (rd == 4'd15);
      end
      MEMWR: begin
        adr_src   = 1'b1;
        reg_src   = 2'b10;
        mem_write = cond_ok;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_24;
        result_src = RES_ALURES;
        pc_write   = cond_ok;
      end
      LINK: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_CTRL_W'(ALU_SUB);
        result_src  = RES_ALURES;
        reg_write   = cond_ok;
      end
      default: ;
    endcase
    // Reset kills every state-changing enable immediately, mid-instruction included.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-cycle expected control bundles are queued per instruction and
// compared cycle by cycle; flag register and abort-on-reset are checked directly.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  typedef struct packed {
    logic       pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, imm_src, reg_src;
    logic       sh_src;
    logic [3:0] alu_control;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instruction;
  logic [3:0]  alu_flags;
  logic        sh_imm;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0]  result_src, alu_src_b, imm_src, reg_src;
  logic        alu_src_a, sh_src, illegal_instr;
  logic [3:0]  alu_control;
  ctl_t        obs;

  int checks = 0;
  int errors = 0;
  sb_t sb_q[$];

  multicycle_control_unit #(.MEM_LATENCY(3), .ALU_CTRL_W(4), .FLAG_W(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_flags(alu_flags),
    .sh_imm(sh_imm), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src),
    .sh_src(sh_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a,
                alu_src_b, imm_src, reg_src, sh_src, alu_control, illegal_instr};

  function automatic ctl_t e_fetch(input logic en);
    ctl_t c = '0;
    c.ir_write = en; c.pc_write = en; c.alu_src_a = 1'b1;
    c.alu_src_b = 2'b10; c.result_src = 2'b10;
    return c;
  endfunction

  function automatic ctl_t e_decode(input logic ill);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.illegal = ill;
    return c;
  endfunction

  function automatic ctl_t e_exec(input logic imm, input logic [3:0] alu);
    ctl_t c = '0;
    c.alu_src_b = imm ? 2'b01 : 2'b00; c.alu_control = alu;
    return c;
  endfunction

  function automatic ctl_t e_aluwb(input logic [3:0] alu, input logic we, input logic pcw);
    ctl_t c = '0;
    c.alu_control = alu; c.reg_write = we; c.pc_write = pcw;
    return c;
  endfunction

  function automatic ctl_t e_memadr();
    ctl_t c = '0;
    c.alu_src_b = 2'b01; c.imm_src = 2'b01;
    return c;
  endfunction

  function automatic ctl_t e_memrd();
    ctl_t c = '0;
    c.adr_src = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_memwb(input logic we);
    ctl_t c = '0;
    c.result_src = 2'b01; c.reg_write = we;
    return c;
  endfunction

  function automatic ctl_t e_memwr(input logic we);
    ctl_t c = '0;
    c.adr_src = 1'b1; c.reg_src = 2'b10; c.mem_write = we;
    return c;
  endfunction

  function automatic ctl_t e_branch(input logic taken);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b01; c.imm_src = 2'b10;
    c.result_src = 2'b10; c.pc_write = taken;
    return c;
  endfunction

  function automatic ctl_t e_link(input logic we);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 4'b0001;
    c.result_src = 2'b10; c.reg_write = we;
    return c;
  endfunction

  task automatic push(input string tag, input ctl_t exp);
    sb_t e;
    e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    sb_t e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  // Drains the scoreboard one clock per entry; returns at the negedge starting the next cycle.
  task automatic run();
    while (sb_q.size() > 0) begin
      #1;
      compare_front();
      @(negedge clk);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    checks++;
    assert (dut.u_cond.flags === exp) else begin
      errors++;
      $error("FAIL %s: observed flags %b expected %b", tag, dut.u_cond.flags, exp);
    end
  endtask

  task automatic start(input logic [19:0] instr, input logic [3:0] fl);
    instruction = instr;
    alu_flags   = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sh_imm = 1'b0;
    start(20'hE3A01, 4'b0000);

    // Held in reset across clock edges: FETCH outputs with all enables off.
    @(negedge clk);
    push("reset_hold", e_fetch(1'b0)); #1; compare_front();
    check_flags("reset_flags", 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // MOV r1,#imm: 4 cycles, PASSB written in ALUWB.
    push("mov_fetch", e_fetch(1'b1));
    push("mov_decode", e_decode(1'b0));
    push("mov_execi", e_exec(1'b1, 4'b0100));
    push("mov_aluwb", e_aluwb(4'b0100, 1'b1, 1'b0));
    run();

    // SUBS: Z from ALU lands in the flag register.
    start(20'hE0512, 4'b0100);
    push("subs_fetch", e_fetch(1'b1));
    push("subs_decode", e_decode(1'b0));
    push("subs_execr", e_exec(1'b0, 4'b0001));
    push("subs_aluwb", e_aluwb(4'b0001, 1'b1, 1'b0));
    run();
    check_flags("subs_flags", 4'b0100);

    // BEQ with Z=1: taken.
    start(20'h0A000, 4'b0000);
    push("beq_t_fetch", e_fetch(1'b1));
    push("beq_t_decode", e_decode(1'b0));
    push("beq_t_branch", e_branch(1'b1));
    run();

    // MOVS with ALU flags 1111: N,Z follow, C,V held at 00.
    start(20'hE3B01, 4'b1111);
    push("movs1_fetch", e_fetch(1'b1));
    push("movs1_decode", e_decode(1'b0));
    push("movs1_execi", e_exec(1'b1, 4'b0100));
    push("movs1_aluwb", e_aluwb(4'b0100, 1'b1, 1'b0));
    run();
    check_flags("movs_cv_hold", 4'b1100);

    start(20'hE3B01, 4'b0000);
    push("movs0_fetch", e_fetch(1'b1));
    push("movs0_decode", e_decode(1'b0));
    push("movs0_execi", e_exec(1'b1, 4'b0100));
    push("movs0_aluwb", e_aluwb(4'b0100, 1'b1, 1'b0));
    run();
    check_flags("movs_clear", 4'b0000);

    // BEQ with Z=0: not taken.
    start(20'h0A000, 4'b0000);
    push("beq_n_fetch", e_fetch(1'b1));
    push("beq_n_decode", e_decode(1'b0));
    push("beq_n_branch", e_branch(1'b0));
    run();

    // LDR with 3-cycle memory: 7 cycles total.
    start(20'hE5912, 4'b0000);
    push("ldr_fetch", e_fetch(1'b1));
    push("ldr_decode", e_decode(1'b0));
    push("ldr_memadr", e_memadr());
    push("ldr_memrd0", e_memrd());
    push("ldr_memrd1", e_memrd());
    push("ldr_memrd2", e_memrd());
    push("ldr_memwb", e_memwb(1'b1));
    run();

    // STR, unconditional then EQ with Z=0.
    start(20'hE5812, 4'b0000);
    push("str_fetch", e_fetch(1'b1));
    push("str_decode", e_decode(1'b0));
    push("str_memadr", e_memadr());
    push("str_memwr", e_memwr(1'b1));
    run();

    start(20'h05812, 4'b0000);
    push("streq_fetch", e_fetch(1'b1));
    push("streq_decode", e_decode(1'b0));
    push("streq_memadr", e_memadr());
    push("streq_memwr", e_memwr(1'b0));
    run();

    // MOV pc: Rd=15 also loads PC.
    start(20'hE3A0F, 4'b0000);
    push("movpc_fetch", e_fetch(1'b1));
    push("movpc_decode", e_decode(1'b0));
    push("movpc_execi", e_exec(1'b1, 4'b0100));
    push("movpc_aluwb", e_aluwb(4'b0100, 1'b1, 1'b1));
    run();

    // cond=1111 never executes.
    start(20'hF3A01, 4'b0000);
    push("nv_fetch", e_fetch(1'b1));
    push("nv_decode", e_decode(1'b0));
    push("nv_execi", e_exec(1'b1, 4'b0100));
    push("nv_aluwb", e_aluwb(4'b0100, 1'b0, 1'b0));
    run();

    // CMP: SUB without write; C/V updated.
    start(20'hE1512, 4'b0010);
    push("cmp_fetch", e_fetch(1'b1));
    push("cmp_decode", e_decode(1'b0));
    push("cmp_execr", e_exec(1'b0, 4'b0001));
    push("cmp_aluwb", e_aluwb(4'b0001, 1'b0, 1'b0));
    run();
    check_flags("cmp_flags", 4'b0010);

    // ADD without S, then reset asserted during ALUWB.
    start(20'hE0812, 4'b1111);
    push("add_fetch", e_fetch(1'b1));
    push("add_decode", e_decode(1'b0));
    push("add_execr", e_exec(1'b0, 4'b0000));
    run();
    push("add_aluwb", e_aluwb(4'b0000, 1'b1, 1'b0));
    #1; compare_front();
    check_flags("add_nos_flags", 4'b0010);
    #1 reset = 1'b1;
    push("abort_outputs", e_fetch(1'b0));
    #1; compare_front();
    checks++;
    assert (dut.state === FETCH) else begin
      errors++;
      $error("FAIL abort_state: observed %0d expected %0d", dut.state, FETCH);
    end
    @(negedge clk);
    reset = 1'b0;
    check_flags("abort_flags", 4'b0000);

    // BL: link cycle only when the option is built in.
    start(20'hEB000, 4'b0000);
    push("bl_fetch", e_fetch(1'b1));
    push("bl_decode", e_decode(1'b0));
`ifdef CU_BRANCH_LINK_EN
    push("bl_link", e_link(1'b1));
`endif
    push("bl_branch", e_branch(1'b1));
    run();

    // Illegal op=11: one-cycle pulse in DECODE, then straight back to FETCH.
    start(20'hEC000, 4'b0000);
    push("ill_fetch", e_fetch(1'b1));
    push("ill_decode", e_decode(1'b1));
    push("ill_refetch", e_fetch(1'b1));
    run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
